// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like data bus: transfer sizes, response entry
// layout and the byte-lane write mask used by both the responder and d_cache.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int COUNTDOWN_WIDTH = 4;

    typedef struct packed {
        logic                       is_write;
        logic [31:0]                rdata;
        logic [COUNTDOWN_WIDTH-1:0] countdown;
    } resp_entry_t;

    // Size 2'b11 is treated as a full word; misaligned offsets only steer the lanes.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << offset;
            SIZE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] mask);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[i*8 +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/sram_like_mem_responder_resp_fifo.sv
// In-order response queue: each entry counts down to zero and becomes
// retireable once it reaches the head with a zero countdown.
module resp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  resp_entry_t                push_entry,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       head_valid,
    output resp_entry_t                head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    resp_entry_t      entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign full       = (count == CNT_W'(DEPTH));
    assign head_valid = (count != '0);
    assign head       = entries[rd_ptr];
    assign do_pop     = pop & head_valid;
    assign do_push    = push & ~full;

    // Idle slots may also tick down; they are overwritten on push before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].countdown != '0) begin
                    entries[i].countdown <= entries[i].countdown - 1'b1;
                end
            end
            if (do_push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_mem_responder.sv
// Memory-side responder for the sram-like bus: word memory with byte-lane
// writes, accesses performed at acceptance, responses returned in order.
module sram_like_mem_responder
    import sram_like_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [COUNTDOWN_WIDTH-1:0] LOAD_COUNT = COUNTDOWN_WIDTH'(LATENCY - 1);

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] word_index;
    logic [31:0]           lane_bits;
    logic                  accept;
    resp_entry_t           push_entry;
    resp_entry_t           head;
    logic                  head_valid;
    logic                  fifo_full;
    logic [CNT_W-1:0]      fifo_count;
    logic                  unused_bits;

    // Upper address bits alias onto the same words.
    assign word_index   = data_addr[ADDR_WIDTH+1:2];
    assign lane_bits    = expand_mask(byte_mask(data_size, data_addr[1:0]));
    assign unused_bits  = ^{fifo_full, data_addr[31:ADDR_WIDTH+2]};

    // No bypass: a full queue refuses even when the head retires this cycle.
    assign data_addr_ok = data_req & (fifo_count < CNT_W'(DEPTH));
    assign accept       = data_req & data_addr_ok;

    assign data_data_ok = head_valid & (head.countdown == '0);
    assign data_rdata   = (data_data_ok & ~head.is_write) ? head.rdata : 32'h0;

    // Memory is deliberately not reset so accepted writes survive a reset.
    always_ff @(posedge clk) begin
        if (accept & data_wr) begin
            mem[word_index] <= (mem[word_index] & ~lane_bits) | (data_wdata & lane_bits);
        end
    end

    always_comb begin
        push_entry           = '0;
        push_entry.is_write  = data_wr;
        push_entry.rdata     = data_wr ? 32'h0 : mem[word_index];
        push_entry.countdown = LOAD_COUNT;
    end

    resp_fifo #(
        .DEPTH(DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_entry(push_entry),
        .pop       (data_data_ok),
        .count     (fifo_count),
        .full      (fifo_full),
        .head_valid(head_valid),
        .head      (head)
    );

endmodule

// File: tb/tb_sram_like_mem_responder.sv
// Directed bench: DUT a runs LATENCY=2/DEPTH=2, DUT b runs LATENCY=4/DEPTH=2
// to exercise back-pressure with a held request.
module tb_sram_like_mem_responder;

    import sram_like_pkg::*;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_req, a_wr, a_addr_ok, a_data_ok;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata;

    logic        b_req, b_wr, b_addr_ok, b_data_ok;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .data_req(a_req), .data_wr(a_wr), .data_size(a_size),
        .data_addr(a_addr), .data_wdata(a_wdata), .data_rdata(a_rdata),
        .data_addr_ok(a_addr_ok), .data_data_ok(a_data_ok)
    );

    sram_like_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4), .DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .data_req(b_req), .data_wr(b_wr), .data_size(b_size),
        .data_addr(b_addr), .data_wdata(b_wdata), .data_rdata(b_rdata),
        .data_addr_ok(b_addr_ok), .data_data_ok(b_data_ok)
    );

    task automatic apply_stimulus(input logic req, input logic wr, input logic [1:0] size,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        a_req = req; a_wr = wr; a_size = size; a_addr = addr; a_wdata = wdata;
    endtask

    task automatic apply_stimulus_b(input logic req, input logic wr, input logic [1:0] size,
                                    input logic [31:0] addr, input logic [31:0] wdata);
        b_req = req; b_wr = wr; b_size = size; b_addr = addr; b_wdata = wdata;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        apply_stimulus_b(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        step();
        step();
        check_bit("rst_a_addr_ok", a_addr_ok, 1'b0);
        check_bit("rst_a_data_ok", a_data_ok, 1'b0);
        check_output("rst_a_rdata", a_rdata, 32'h0);
        check_bit("rst_b_data_ok", b_data_ok, 1'b0);
        apply_stimulus(1'b1, 1'b0, SIZE_WORD, 32'h10, 32'h0);
        #1;
        check_bit("rst_req_addr_ok", a_addr_ok, 1'b1);
        apply_stimulus(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        step();
        rst = 1'b0;

        $display("[TB] word write then read");
        apply_stimulus(1'b1, 1'b1, SIZE_WORD, 32'h10, 32'hDEADBEEF);
        #1;
        check_bit("t0_addr_ok", a_addr_ok, 1'b1);
        check_bit("t0_data_ok", a_data_ok, 1'b0);
        step();
        apply_stimulus(1'b1, 1'b0, SIZE_WORD, 32'h10, 32'h0);
        #1;
        check_bit("t1_addr_ok", a_addr_ok, 1'b1);
        check_bit("t1_data_ok", a_data_ok, 1'b0);
        step();
        apply_stimulus(1'b1, 1'b0, SIZE_WORD, 32'h14, 32'h0);
        #1;
        check_bit("t2_full_no_bypass", a_addr_ok, 1'b0);
        check_bit("t2_wr_data_ok", a_data_ok, 1'b1);
        check_output("t2_wr_rdata", a_rdata, 32'h0);
        step();
        apply_stimulus(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check_bit("t3_rd_data_ok", a_data_ok, 1'b1);
        check_output("t3_rd_rdata", a_rdata, 32'hDEADBEEF);
        step();

        $display("[TB] byte and half lane writes");
        apply_stimulus(1'b1, 1'b1, SIZE_BYTE, 32'h13, 32'hAA000000);
        #1;
        check_bit("t4_idle_data_ok", a_data_ok, 1'b0);
        check_bit("t4_addr_ok", a_addr_ok, 1'b1);
        step();
        apply_stimulus(1'b1, 1'b1, SIZE_HALF, 32'h10, 32'h00005555);
        #1;
        check_bit("t5_addr_ok", a_addr_ok, 1'b1);
        step();
        apply_stimulus(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check_bit("t6_data_ok", a_data_ok, 1'b1);
        check_output("t6_rdata", a_rdata, 32'h0);
        step();
        apply_stimulus(1'b1, 1'b0, SIZE_WORD, 32'h10, 32'h0);
        #1;
        check_bit("t7_push_pop_addr_ok", a_addr_ok, 1'b1);
        check_bit("t7_push_pop_data_ok", a_data_ok, 1'b1);
        step();
        apply_stimulus(1'b1, 1'b0, SIZE_WORD, 32'h1000_0010, 32'h0);
        #1;
        check_bit("t8_addr_ok", a_addr_ok, 1'b1);
        check_bit("t8_data_ok", a_data_ok, 1'b0);
        step();
        apply_stimulus(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check_bit("t9_data_ok", a_data_ok, 1'b1);
        check_output("t9_merged_rdata", a_rdata, 32'hAAAD5555);
        step();
        check_bit("t10_data_ok", a_data_ok, 1'b1);
        check_output("t10_alias_rdata", a_rdata, 32'hAAAD5555);
        step();

        $display("[TB] reset with reads outstanding");
        apply_stimulus(1'b1, 1'b1, SIZE_WORD, 32'h20, 32'h12345678);
        #1;
        check_bit("t11_no_dup_data_ok", a_data_ok, 1'b0);
        step();
        apply_stimulus(1'b1, 1'b0, SIZE_WORD, 32'h10, 32'h0);
        #1;
        check_bit("t12_addr_ok", a_addr_ok, 1'b1);
        step();
        apply_stimulus(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check_bit("t13_data_ok", a_data_ok, 1'b1);
        step();
        apply_stimulus(1'b1, 1'b0, SIZE_WORD, 32'h20, 32'h0);
        #1;
        check_output("t14_rdata", a_rdata, 32'hAAAD5555);
        step();
        apply_stimulus(1'b1, 1'b0, SIZE_WORD, 32'h10, 32'h0);
        #1;
        check_bit("t15_addr_ok", a_addr_ok, 1'b1);
        step();
        apply_stimulus(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        check_output("t16_rdata", a_rdata, 32'h12345678);
        step();
        rst = 1'b0;
        #1;
        check_bit("t17_dropped_data_ok", a_data_ok, 1'b0);
        check_output("t17_dropped_rdata", a_rdata, 32'h0);
        step();
        check_bit("t18_dropped_data_ok", a_data_ok, 1'b0);
        step();
        apply_stimulus(1'b1, 1'b0, SIZE_WORD, 32'h20, 32'h0);
        #1;
        check_bit("t19_addr_ok", a_addr_ok, 1'b1);
        check_bit("t19_data_ok", a_data_ok, 1'b0);
        step();
        apply_stimulus(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check_bit("t20_data_ok", a_data_ok, 1'b0);
        step();
        check_bit("t21_data_ok", a_data_ok, 1'b1);
        check_output("t21_kept_rdata", a_rdata, 32'h12345678);
        step();
        check_bit("t22_data_ok", a_data_ok, 1'b0);

        $display("[TB] held request with LATENCY=4");
        apply_stimulus_b(1'b1, 1'b1, SIZE_WORD, 32'h4, 32'h11111111);
        #1;
        check_bit("c0_addr_ok", b_addr_ok, 1'b1);
        step();
        apply_stimulus_b(1'b1, 1'b1, SIZE_WORD, 32'h8, 32'h22222222);
        #1;
        check_bit("c1_addr_ok", b_addr_ok, 1'b1);
        step();
        apply_stimulus_b(1'b1, 1'b0, SIZE_WORD, 32'h4, 32'h0);
        #1;
        check_bit("c2_addr_ok", b_addr_ok, 1'b0);
        check_bit("c2_data_ok", b_data_ok, 1'b0);
        step();
        check_bit("c3_addr_ok", b_addr_ok, 1'b0);
        check_bit("c3_data_ok", b_data_ok, 1'b0);
        step();
        check_bit("c4_addr_ok", b_addr_ok, 1'b0);
        check_bit("c4_data_ok", b_data_ok, 1'b1);
        step();
        check_bit("c5_addr_ok", b_addr_ok, 1'b1);
        check_bit("c5_data_ok", b_data_ok, 1'b1);
        check_output("c5_rdata", b_rdata, 32'h0);
        step();
        apply_stimulus_b(1'b1, 1'b0, SIZE_WORD, 32'h8, 32'h0);
        #1;
        check_bit("c6_addr_ok", b_addr_ok, 1'b1);
        check_bit("c6_data_ok", b_data_ok, 1'b0);
        step();
        apply_stimulus_b(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        #1;
        check_bit("c7_data_ok", b_data_ok, 1'b0);
        step();
        check_bit("c8_data_ok", b_data_ok, 1'b0);
        step();
        check_bit("c9_data_ok", b_data_ok, 1'b1);
        check_output("c9_rdata", b_rdata, 32'h11111111);
        step();
        check_bit("c10_data_ok", b_data_ok, 1'b1);
        check_output("c10_rdata", b_rdata, 32'h22222222);
        step();
        check_bit("c11_data_ok", b_data_ok, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
